// File: rtl/sha_nonce_scheduler.sv
// sha_nonce_scheduler: hands (time, nonce) work to LANES parallel double-SHA
// cores every cycle, realigns the per-lane hit flags returning PIPE_LAT cycles
// later through a delay line, and queues winning (time, nonce) pairs in a
// show-ahead valid/ready FIFO.
// Optional build macro SHA_SCHED_STATS_EN adds hit_count / drop_count outputs.
module sha_nonce_scheduler #(
  parameter int LANES      = 4,
  parameter int PIPE_LAT   = 130,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                write_en,
  input  logic [31:0]         time_in,
  input  logic [31:0]         nonce_in,
  input  logic                run_en,
  output logic                lane_valid,
  output logic [31:0]         lane_time,
  output logic [32*LANES-1:0] lane_nonce,
  input  logic [LANES-1:0]    hit_in,
  output logic                hit_valid,
  output logic [31:0]         hit_time,
  output logic [31:0]         hit_nonce,
  input  logic                hit_ready,
  output logic                busy,
  output logic                overflow
`ifdef SHA_SCHED_STATS_EN
  ,
  output logic [31:0]         hit_count,
  output logic [31:0]         drop_count
`endif
);

  localparam int          LW        = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int          PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [31:0] LANE_STEP = 32'(LANES);
  localparam logic [31:0] BASE_MASK = ~(LANE_STEP - 32'd1);
  // Last base before the nonce space wraps; issuing it carries into time.
  localparam logic [31:0] BASE_LAST = 32'd0 - LANE_STEP;
  localparam logic [PW:0] DEPTH_CNT = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        r_state;
  logic [31:0]   r_time_ctr;
  logic [31:0]   r_base;
  logic          w_issue;

  // Delay line: valid bits carry reset/flush, payload needs none.
  logic [PIPE_LAT-1:0] r_dl_valid;
  logic [31:0]         r_dl_time [PIPE_LAT];
  logic [31:0]         r_dl_base [PIPE_LAT];

  logic [LW-1:0] w_hit_lane;
  logic          w_capture;
  logic [31:0]   w_push_nonce;

  logic [63:0]   r_fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop_full;

  assign w_issue    = run_en & (r_state == S_RUN);
  assign lane_valid = w_issue;
  assign lane_time  = r_time_ctr;
  assign busy       = (r_state == S_RUN) | (|r_dl_valid);

  // Job FSM with base/time counters; a carry out of the nonce space bumps time
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= S_IDLE;
      r_time_ctr <= '0;
      r_base     <= '0;
    end else if (write_en) begin
      r_state    <= S_RUN;
      r_time_ctr <= time_in;
      r_base     <= nonce_in & BASE_MASK;
    end else if (w_issue) begin
      r_base <= r_base + LANE_STEP;
      if (r_base == BASE_LAST) begin
        r_time_ctr <= r_time_ctr + 32'd1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [31:0] r_nonce;
      // Per-lane registered nonce tracking base+gi
      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          r_nonce <= '0;
        end else if (write_en) begin
          r_nonce <= (nonce_in & BASE_MASK) + 32'(gi);
        end else if (w_issue) begin
          r_nonce <= r_nonce + LANE_STEP;
        end
      end
      assign lane_nonce[32*gi +: 32] = r_nonce;
    end
  endgenerate

  // Valid bits shift every cycle; write_en wipes all in-flight work
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_dl_valid <= '0;
    end else if (write_en) begin
      r_dl_valid <= '0;
    end else begin
      r_dl_valid <= {r_dl_valid[PIPE_LAT-2:0], w_issue};
    end
  end

  // Payload shift of the issued (time, base) alongside the valid bits
  always_ff @(posedge CLK) begin
    r_dl_time[0] <= r_time_ctr;
    r_dl_base[0] <= r_base;
    for (int i = 1; i < PIPE_LAT; i++) begin
      r_dl_time[i] <= r_dl_time[i-1];
      r_dl_base[i] <= r_dl_base[i-1];
    end
  end

  // Lowest set lane wins; higher lanes in the same cycle are dropped
  always_comb begin
    w_hit_lane = '0;
    for (int k = LANES - 1; k >= 0; k--) begin
      if (hit_in[k]) w_hit_lane = LW'(k);
    end
  end

  assign w_capture    = r_dl_valid[PIPE_LAT-1] & (|hit_in) & ~write_en;
  assign w_push_nonce = r_dl_base[PIPE_LAT-1] + 32'(w_hit_lane);

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == DEPTH_CNT);
  assign w_pop       = hit_ready & ~w_empty;
  assign w_push      = w_capture & (~w_full | w_pop);
  assign w_drop_full = w_capture & w_full & ~w_pop;

  assign hit_valid = ~w_empty;
  assign hit_time  = w_empty ? 32'd0 : r_fifo_mem[r_rd_ptr][63:32];
  assign hit_nonce = w_empty ? 32'd0 : r_fifo_mem[r_rd_ptr][31:0];

  // Solution storage; read side is show-ahead from the head pointer
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr] <= {r_dl_time[PIPE_LAT-1], w_push_nonce};
    end
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (write_en) begin
        overflow <= 1'b0;
      end else if (w_drop_full) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef SHA_SCHED_STATS_EN
  logic [31:0] w_hit_bits;
  logic [31:0] w_stat_hits;
  logic [31:0] w_stat_drops;
  logic [32:0] w_hit_sum;
  logic [32:0] w_drop_sum;

  // Count of set hit lanes this cycle
  always_comb begin
    w_hit_bits = '0;
    for (int k = 0; k < LANES; k++) begin
      w_hit_bits = w_hit_bits + 32'(hit_in[k]);
    end
  end

  assign w_stat_hits  = w_capture ? w_hit_bits : 32'd0;
  assign w_stat_drops = w_capture ? (w_hit_bits - 32'd1 + 32'(w_drop_full)) : 32'd0;
  assign w_hit_sum    = {1'b0, hit_count} + {1'b0, w_stat_hits};
  assign w_drop_sum   = {1'b0, drop_count} + {1'b0, w_stat_drops};

  // Saturating statistics counters, cleared with each new job
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hit_count  <= '0;
      drop_count <= '0;
    end else if (write_en) begin
      hit_count  <= '0;
      drop_count <= '0;
    end else begin
      hit_count  <= w_hit_sum[32] ? 32'hFFFF_FFFF : w_hit_sum[31:0];
      drop_count <= w_drop_sum[32] ? 32'hFFFF_FFFF : w_drop_sum[31:0];
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_sha_nonce_scheduler.sv
// Testbench for sha_nonce_scheduler (LANES=4, PIPE_LAT=8, FIFO_DEPTH=4).
// Hits are scheduled per cycle in hit_plan; expected solutions go into a
// queue when scheduled and are popped when the DUT hands them out.
module tb_sha_nonce_scheduler;
  localparam int LANES      = 4;
  localparam int PIPE_LAT   = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int PLAN_LEN   = 512;

  logic                CLK = 1'b0;
  logic                RST = 1'b0;
  logic                write_en = 1'b0;
  logic [31:0]         time_in = '0;
  logic [31:0]         nonce_in = '0;
  logic                run_en = 1'b0;
  logic [LANES-1:0]    hit_in = '0;
  logic                hit_ready = 1'b0;
  logic                lane_valid;
  logic [31:0]         lane_time;
  logic [32*LANES-1:0] lane_nonce;
  logic                hit_valid;
  logic [31:0]         hit_time;
  logic [31:0]         hit_nonce;
  logic                busy;
  logic                overflow;
`ifdef SHA_SCHED_STATS_EN
  logic [31:0]         hit_count;
  logic [31:0]         drop_count;
`endif

  sha_nonce_scheduler #(
    .LANES(LANES), .PIPE_LAT(PIPE_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .CLK(CLK), .RST(RST), .write_en(write_en), .time_in(time_in),
    .nonce_in(nonce_in), .run_en(run_en), .lane_valid(lane_valid),
    .lane_time(lane_time), .lane_nonce(lane_nonce), .hit_in(hit_in),
    .hit_valid(hit_valid), .hit_time(hit_time), .hit_nonce(hit_nonce),
    .hit_ready(hit_ready), .busy(busy), .overflow(overflow)
`ifdef SHA_SCHED_STATS_EN
    , .hit_count(hit_count), .drop_count(drop_count)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct packed { logic [31:0] t; logic [31:0] n; } sol_t;
  typedef struct { int issue; logic [3:0] pat; int off; bit push; } vec_t;
  typedef struct { logic [31:0] t; logic [31:0] b; } wrap_t;

  sol_t       exp_q[$];
  logic [3:0] hit_plan [PLAN_LEN];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    chk(name, 32'(act), 32'(req));
  endtask

  // One clock: scoreboard pop check at negedge, then advance to posedge+1
  task automatic tick();
    sol_t e;
    @(negedge CLK);
    if (hit_valid && hit_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %h/%h required no entry (cycle %0d)",
                 hit_time, hit_nonce, cyc);
      end else begin
        e = exp_q.pop_front();
        if (hit_time !== e.t || hit_nonce !== e.n) begin
          errors++;
          $display("FAIL pop: got %h/%h required %h/%h (cycle %0d)",
                   hit_time, hit_nonce, e.t, e.n, cyc);
        end else begin
          $display("pop   cycle %0d time=%h nonce=%h", cyc, hit_time, hit_nonce);
        end
      end
    end
    @(posedge CLK);
    #1;
    cyc++;
    hit_in = (cyc < PLAN_LEN) ? hit_plan[cyc] : 4'h0;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic plan(input int c, input logic [3:0] p);
    if (c >= 0 && c < PLAN_LEN) hit_plan[c] = p;
  endtask

  initial begin
    int          c;
    logic [31:0] b;
    wrap_t       wrap_tab [5];
    vec_t        vec_tab [6];

    for (int i = 0; i < PLAN_LEN; i++) hit_plan[i] = 4'h0;
    wrap_tab[0] = '{32'hAAAAAAA1, 32'hFFFFFFF0};
    wrap_tab[1] = '{32'hAAAAAAA1, 32'hFFFFFFF4};
    wrap_tab[2] = '{32'hAAAAAAA1, 32'hFFFFFFF8};
    wrap_tab[3] = '{32'hAAAAAAA1, 32'hFFFFFFFC};
    wrap_tab[4] = '{32'hAAAAAAA2, 32'h00000000};
    vec_tab[0]  = '{0, 4'b1010, 1, 1'b1};
    vec_tab[1]  = '{2, 4'b0100, 2, 1'b1};
    vec_tab[2]  = '{3, 4'b1000, 3, 1'b1};
    vec_tab[3]  = '{5, 4'b1111, 0, 1'b1};
    vec_tab[4]  = '{6, 4'b0000, 0, 1'b0};
    vec_tab[5]  = '{7, 4'b0110, 1, 1'b1};

    // Reset held: everything at zero
    run_en = 1'b1;
    repeat (3) tick();
    settle();
    chk1("rst_lane_valid", lane_valid, 1'b0);
    chk("rst_lane_time", lane_time, 32'd0);
    chk1("rst_lane_nonce_any", |lane_nonce, 1'b0);
    chk1("rst_hit_valid", hit_valid, 1'b0);
    chk("rst_hit_time", hit_time, 32'd0);
    chk("rst_hit_nonce", hit_nonce, 32'd0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_overflow", overflow, 1'b0);
    RST = 1'b1;

    // Released with no job loaded: nothing issues
    for (int i = 0; i < 20; i++) begin
      tick();
      settle();
      chk1("idle_lane_valid", lane_valid, 1'b0);
      chk1("idle_hit_valid", hit_valid, 1'b0);
      chk1("idle_busy", busy, 1'b0);
    end

    // Nonce wrap carries into the time word
    time_in = 32'hAAAAAAA1; nonce_in = 32'hFFFFFFF2; write_en = 1'b1;
    tick();
    write_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      $display("issue cycle %0d valid=%0b time=%h base=%h", cyc, lane_valid, lane_time, lane_nonce[31:0]);
      chk1($sformatf("wrap%0d_valid", i), lane_valid, 1'b1);
      chk($sformatf("wrap%0d_time", i), lane_time, wrap_tab[i].t);
      for (int k = 0; k < LANES; k++)
        chk($sformatf("wrap%0d_nonce%0d", i, k), lane_nonce[32*k +: 32], wrap_tab[i].b + 32'(k));
      chk1($sformatf("wrap%0d_busy", i), busy, 1'b1);
      tick();
    end

    // Hit latency, plus stale hits from before the reload are discarded
    hit_ready = 1'b0;
    time_in = 32'h130dae51; nonce_in = 32'h3aeb9bb0; write_en = 1'b1; c = cyc;
    plan(c - 1 + PIPE_LAT, 4'hF);
    plan(c + PIPE_LAT, 4'hF);
    plan(c + 3 + PIPE_LAT, 4'b0001);
    exp_q.push_back('{32'h130dae51, 32'h3aeb9bb8});
    tick();
    write_en = 1'b0;
    while (cyc < c + 3 + PIPE_LAT + 1) begin
      settle();
      if (cyc == c + 3) chk("lat_third_base", lane_nonce[31:0], 32'h3aeb9bb8);
      chk1("lat_no_early_hit", hit_valid, 1'b0);
      tick();
    end
    settle();
    chk1("lat_hit_valid", hit_valid, 1'b1);
    chk("lat_hit_time", hit_time, 32'h130dae51);
    chk("lat_hit_nonce", hit_nonce, 32'h3aeb9bb8);
    hit_ready = 1'b1;
    tick();
    tick();
    chk("lat_drained", 32'(exp_q.size()), 32'd0);

    // Table of lane patterns on one job
    time_in = 32'h5eed0001; nonce_in = 32'h12345677; write_en = 1'b1; c = cyc;
    b = 32'h12345674;
    for (int v = 0; v < 6; v++) begin
      plan(c + 1 + vec_tab[v].issue + PIPE_LAT, vec_tab[v].pat);
      if (vec_tab[v].push)
        exp_q.push_back('{32'h5eed0001, b + 32'(4 * vec_tab[v].issue + vec_tab[v].off)});
    end
    tick();
    write_en = 1'b0;
    for (int i = 0; i < 30; i++) begin
`ifdef SHA_SCHED_STATS_EN
      if (cyc == c + 10) begin
        settle();
        chk("stats_collision_drop", drop_count, 32'd1);
      end
`endif
      tick();
    end
    chk("table_drained", 32'(exp_q.size()), 32'd0);
`ifdef SHA_SCHED_STATS_EN
    chk("stats_hit_count", hit_count, 32'd10);
    chk("stats_drop_count", drop_count, 32'd5);
`endif

    // Pause for 3 cycles with hits held high; flush at the reload cycle
    time_in = 32'h00000007; nonce_in = 32'h80000003; write_en = 1'b1; c = cyc;
    b = 32'h80000000;
    hit_in = 4'hF;
    for (int i = c; i <= c + 26; i++) plan(i, 4'hF);
    for (int n = 0; n < 7; n++) exp_q.push_back('{32'h00000007, b + 32'(4 * n)});
    tick();
    write_en = 1'b0;
    for (int o = 1; o <= 26; o++) begin
      run_en = (o <= 4) || (o >= 8 && o <= 10);
      settle();
      if (o >= 5 && o <= 7) begin
        chk1("pause_valid", lane_valid, 1'b0);
        chk("pause_base_held", lane_nonce[31:0], b + 32'd16);
      end
      if (o == 8) begin
        chk1("resume_valid", lane_valid, 1'b1);
        chk("resume_base", lane_nonce[31:0], b + 32'd16);
      end
      tick();
    end
    chk("pause_drained", 32'(exp_q.size()), 32'd0);

    // FIFO full: one drop sets overflow, then simultaneous push+pop when full
    run_en = 1'b1; hit_ready = 1'b0;
    time_in = 32'hCAFE0000; nonce_in = 32'h00000100; write_en = 1'b1; c = cyc;
    b = 32'h00000100;
    for (int n = 0; n < 6; n++) begin
      plan(c + 1 + n + PIPE_LAT, 4'b0001);
      if (n != 4) exp_q.push_back('{32'hCAFE0000, b + 32'(4 * n)});
    end
    tick();
    write_en = 1'b0;
    while (cyc < c + 20) begin
      hit_ready = (cyc == c + 14);
      settle();
      if (cyc == c + 13) begin
        chk1("full_hit_valid", hit_valid, 1'b1);
        chk1("ovf_before_drop", overflow, 1'b0);
      end
      if (cyc == c + 14) chk1("ovf_after_drop", overflow, 1'b1);
      tick();
    end
    hit_ready = 1'b0;
    settle();
    chk1("ovf_sticky", overflow, 1'b1);

    // Reload clears overflow but keeps the queued solutions in order
    run_en = 1'b0; time_in = 32'd0; nonce_in = 32'd0; write_en = 1'b1;
    tick();
    write_en = 1'b0;
    settle();
    chk1("reload_ovf_clear", overflow, 1'b0);
    chk1("reload_fifo_kept", hit_valid, 1'b1);
    chk("reload_head_time", hit_time, 32'hCAFE0000);
    chk("reload_head_nonce", hit_nonce, 32'h00000104);
    chk1("reload_no_issue", lane_valid, 1'b0);
    hit_ready = 1'b1;
    repeat (6) tick();
    settle();
    chk1("drain_empty", hit_valid, 1'b0);
    chk("drain_queue", 32'(exp_q.size()), 32'd0);
    repeat (2) tick();
    settle();
    chk1("pop_empty_ignored", hit_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sha_nonce_scheduler.md
Name: sha_nonce_scheduler

Overview:
- Parametrised successor to the single-lane nonce/time counter inside the hasher.
- Issues (time, nonce) work to LANES parallel external double-SHA cores every cycle; nonce overflow rolls into the time counter.
- Absorbs per-lane hit flags returning PIPE_LAT cycles later and reconstructs the exact winning (time, nonce) from a delay line, so no arithmetic rollback is needed.
- Queues solutions in a small valid/ready FIFO for the host.

Parameters:
LANES, 4, parallel hash lanes; power of two, 1..16
PIPE_LAT, 130, cycles from issue to the corresponding hit_in; >=2
FIFO_DEPTH, 8, solution FIFO entries; power of two >=2

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-low reset
write_en  in  1  load new job from time_in/nonce_in; flush in-flight work
time_in  in  32  starting time word
nonce_in  in  32  starting nonce; low log2(LANES) bits ignored (treated as 0)
run_en  in  1  1 = issue work every cycle; 0 = pause issuing
lane_valid  out  1  work issued this cycle
lane_time  out  32  time word for all lanes this cycle
lane_nonce  out  32*LANES  lane k slice [32k+31:32k] = base+k
hit_in  in  LANES  per-lane "result below target"; meaningful only PIPE_LAT cycles after a lane_valid cycle
hit_valid  out  1  FIFO non-empty (show-ahead)
hit_time  out  32  head entry time
hit_nonce  out  32  head entry nonce
hit_ready  in  1  pop head when hit_valid & hit_ready
busy  out  1  state RUN or any in-flight delay-line entry valid
overflow  out  1  sticky: a hit was dropped because the FIFO was full

Behaviour:
- Reset (RST=0): state IDLE; lane_valid=0, lane_time=0, lane_nonce=0, hit_valid=0, hit_time=0, hit_nonce=0, busy=0, overflow=0; delay line invalid; FIFO empty.
- FSM IDLE -> RUN on write_en. RUN stays RUN; a write_en in RUN reloads the job. No exit other than reset; pausing is done with run_en.
- write_en at edge E: base <= nonce_in & ~(LANES-1), time_ctr <= time_in.
  - All delay-line valid bits are cleared at E, so stale hits are discarded.
  - overflow is cleared. FIFO contents are retained.
- Issue: during cycle E+1 onward, lane_valid = run_en & (state==RUN), lane_time = time_ctr, lane_nonce[k] = base+k.
  - Each edge with lane_valid=1: base <= base+LANES mod 2^32.
  - If base == 2^32-LANES, time_ctr <= time_ctr+1 (wraps at 2^32).
  - run_en=0 holds base and time_ctr.
- Outputs lane_* are registered; they reflect the counters, not a combinational path from run_en beyond the valid gating.
- Delay line: PIPE_LAT-deep shift of {valid, time, base}, advancing every cycle.
  - The tail entry aligns with hit_in for the issue made PIPE_LAT cycles earlier.
  - Entries with valid=0 (paused or flushed) ignore hit_in.
- Hit capture: if the tail is valid and hit_in != 0, take the lowest set lane k.
  - Push {tail.time, tail.base+k}.
  - Additional set lanes in the same cycle are dropped.
- Hit latency: a hit_in presented in cycle i+PIPE_LAT for an issue in cycle i gives hit_valid=1 in cycle i+PIPE_LAT+1 (FIFO previously empty).
- FIFO boundaries:
  - Push when full and no pop: entry dropped, overflow <= 1.
  - Push and pop in the same cycle when full: both accepted, count unchanged.
  - Pop when empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- write_en and a hit capture in the same cycle: the capture is discarded (the flush wins).
- Reset mid-operation: everything returns to reset values immediately (asynchronous).

Optional Feature:
- Macro SHA_SCHED_STATS_EN.
- When defined: adds output ports hit_count (32) and drop_count (32).
  - hit_count counts every set hit_in bit on a valid tail.
  - drop_count counts hits lost to multi-lane collision or a full FIFO.
  - Both saturate at 32'hFFFFFFFF, reset to 0, and are cleared by write_en.
- When undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Bench uses LANES=4, PIPE_LAT=8, FIFO_DEPTH=4.
- Reset hold then release with no write_en -> lane_valid=0, hit_valid=0, busy=0 for 20 cycles.
- write_en with time_in=AAAAAAA1, nonce_in=FFFFFFF2 -> issue bases FFFFFFF0, FFFFFFF4, FFFFFFF8, FFFFFFFC at time AAAAAAA1, then 00000000 at time AAAAAAA2.
- write_en with time_in=130dae51, nonce_in=3aeb9bb0; drive hit_in=4'b0001 exactly 8 cycles after the third issue -> hit_valid next cycle with hit_time=130dae51, hit_nonce=3aeb9bb8.
- hit_in=4'b1010 on one valid tail -> single entry with nonce base+1; drop_count=1 when SHA_SCHED_STATS_EN.
- Drive run_en=0 for 3 cycles mid-run with hit_in=4'hF held continuously -> no pushes for the paused slots; base resumes without a gap.
- Hold hit_ready=0 and generate 5 hits -> 4 entries, overflow=1.
- Then issue write_en -> overflow=0, FIFO still pops 4 entries in order.
- Also: a hit aligned with an issue made just before write_en is never pushed.
